// File: rtl/bus_arbiter_if.sv
// Signal bundle between the fetch/memory requesters, the arbiter and the bus slave.
// The arbiter connects through the slave modport; the environment uses master.
interface bus_arbiter_if;
   logic        fetch_req;
   logic [31:0] fetch_address;
   logic        fetch_ready;
   logic [31:0] fetch_data;
   logic        fetch_error;

   logic        mem_load;
   logic        mem_store;
   logic [31:0] mem_address;
   logic [31:0] mem_store_data;
   logic [1:0]  mem_size;
   logic        mem_signed;
   logic        mem_ready;
   logic [31:0] mem_load_data;
   logic        mem_error;

   logic        bus_valid;
   logic        bus_write;
   logic [31:0] bus_address;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_strobe;
   logic        bus_ready;
   logic [31:0] bus_rdata;

   modport slave (
      input  fetch_req, fetch_address,
      output fetch_ready, fetch_data, fetch_error,
      input  mem_load, mem_store, mem_address, mem_store_data, mem_size, mem_signed,
      output mem_ready, mem_load_data, mem_error,
      output bus_valid, bus_write, bus_address, bus_wdata, bus_strobe,
      input  bus_ready, bus_rdata
   );

   modport master (
      output fetch_req, fetch_address,
      input  fetch_ready, fetch_data, fetch_error,
      output mem_load, mem_store, mem_address, mem_store_data, mem_size, mem_signed,
      input  mem_ready, mem_load_data, mem_error,
      input  bus_valid, bus_write, bus_address, bus_wdata, bus_strobe,
      output bus_ready, bus_rdata
   );
endinterface

// File: rtl/bus_arbiter.sv
// Two-requester (fetch / load-store) arbiter onto a single 32-bit bus with byte lanes.
// Define BUS_TIMEOUT_EN to abort transfers after TIMEOUT_CYCLES bus-wait cycles.
module bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic         clk,
   input  logic         rst_n,
   bus_arbiter_if.slave bus_if
);

   typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, MEM = 2'd2} state_e;

   state_e      state_q, state_d;
   logic        last_grant_q, last_grant_d;
   logic        bus_valid_q, bus_valid_d;
   logic        bus_write_q, bus_write_d;
   logic [31:0] bus_address_q, bus_address_d;
   logic [31:0] bus_wdata_q, bus_wdata_d;
   logic [3:0]  bus_strobe_q, bus_strobe_d;
   logic        fetch_ready_q, fetch_ready_d;
   logic [31:0] fetch_data_q, fetch_data_d;
   logic        mem_ready_q, mem_ready_d;
   logic [31:0] mem_load_data_q, mem_load_data_d;
   logic [1:0]  off_q, off_d;
   logic [1:0]  size_q, size_d;
   logic        signed_q, signed_d;

   logic mem_req_s, grant_s, pick_mem_s, done_s, tmo_expire_s;

   function automatic logic [3:0] strobe_f(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] s;
      case (size)
         2'b00:   s = 4'b0001 << off;
         2'b01:   s = 4'b0011 << {off[1], 1'b0};
         default: s = 4'b1111;
      endcase
      return s;
   endfunction

   function automatic logic [31:0] wdata_f(input logic [1:0] size, input logic [31:0] d);
      logic [31:0] w;
      case (size)
         2'b00:   w = {4{d[7:0]}};
         2'b01:   w = {2{d[15:0]}};
         default: w = d;
      endcase
      return w;
   endfunction

   function automatic logic [31:0] load_f(input logic [1:0] size, input logic [1:0] off,
                                          input logic sgn, input logic [31:0] rd);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = rd[{off, 3'b000} +: 8];
      h = off[1] ? rd[31:16] : rd[15:0];
      case (size)
         2'b00:   r = {{24{sgn & b[7]}}, b};
         2'b01:   r = {{16{sgn & h[15]}}, h};
         default: r = rd;
      endcase
      return r;
   endfunction

   assign mem_req_s  = bus_if.mem_load | bus_if.mem_store;
   // The IDLE cycle carrying a ready pulse never grants, so a requester still holding its
   // request while it sees ready is not served twice.
   assign grant_s    = (state_q == IDLE) && !(fetch_ready_q || mem_ready_q) &&
                       (bus_if.fetch_req || mem_req_s);
   assign pick_mem_s = mem_req_s && (!bus_if.fetch_req || !last_grant_q);
   assign done_s     = (state_q != IDLE) && bus_valid_q && bus_if.bus_ready;

`ifdef BUS_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_q, tmo_d;
   logic          fetch_error_q, mem_error_q;

   assign tmo_expire_s = bus_valid_q && !bus_if.bus_ready && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

   // Bus-wait counter: restarts on each grant, advances on every stalled cycle.
   always_comb begin
      tmo_d = tmo_q;
      if (grant_s) begin
         tmo_d = '0;
      end else if (bus_valid_q && !bus_if.bus_ready) begin
         tmo_d = tmo_q + TW'(1);
      end else begin
         tmo_d = tmo_q;
      end
   end

   // Counter and error-pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_q         <= '0;
         fetch_error_q <= 1'b0;
         mem_error_q   <= 1'b0;
      end else begin
         tmo_q         <= tmo_d;
         fetch_error_q <= tmo_expire_s && (state_q == FETCH);
         mem_error_q   <= tmo_expire_s && (state_q == MEM);
      end
   end

   assign bus_if.fetch_error = fetch_error_q;
   assign bus_if.mem_error   = mem_error_q;
`else
   assign tmo_expire_s       = 1'b0;
   assign bus_if.fetch_error = 1'b0;
   assign bus_if.mem_error   = 1'b0;
`endif

   // Next-state and registered-output logic of the arbitration FSM.
   always_comb begin
      state_d         = state_q;
      last_grant_d    = last_grant_q;
      bus_valid_d     = bus_valid_q;
      bus_write_d     = bus_write_q;
      bus_address_d   = bus_address_q;
      bus_wdata_d     = bus_wdata_q;
      bus_strobe_d    = bus_strobe_q;
      fetch_ready_d   = 1'b0;
      fetch_data_d    = fetch_data_q;
      mem_ready_d     = 1'b0;
      mem_load_data_d = mem_load_data_q;
      off_d           = off_q;
      size_d          = size_q;
      signed_d        = signed_q;
      case (state_q)
         IDLE: begin
            if (grant_s && pick_mem_s) begin
               state_d       = MEM;
               bus_valid_d   = 1'b1;
               bus_write_d   = bus_if.mem_store;
               bus_address_d = {bus_if.mem_address[31:2], 2'b00};
               bus_wdata_d   = bus_if.mem_store ? wdata_f(bus_if.mem_size, bus_if.mem_store_data) : 32'd0;
               bus_strobe_d  = strobe_f(bus_if.mem_size, bus_if.mem_address[1:0]);
               off_d         = bus_if.mem_address[1:0];
               size_d        = bus_if.mem_size;
               signed_d      = bus_if.mem_signed;
            end else if (grant_s) begin
               state_d       = FETCH;
               bus_valid_d   = 1'b1;
               bus_write_d   = 1'b0;
               bus_address_d = {bus_if.fetch_address[31:2], 2'b00};
               bus_wdata_d   = 32'd0;
               bus_strobe_d  = 4'b1111;
            end else begin
               state_d = IDLE;
            end
         end
         FETCH, MEM: begin
            if (done_s || tmo_expire_s) begin
               state_d      = IDLE;
               bus_valid_d  = 1'b0;
               bus_write_d  = 1'b0;
               last_grant_d = (state_q == MEM);
               if (state_q == FETCH) begin
                  fetch_ready_d = 1'b1;
                  fetch_data_d  = done_s ? bus_if.bus_rdata : 32'd0;
               end else begin
                  mem_ready_d     = 1'b1;
                  mem_load_data_d = done_s ? load_f(size_q, off_q, signed_q, bus_if.bus_rdata) : 32'd0;
               end
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d     = IDLE;
            bus_valid_d = 1'b0;
            bus_write_d = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         last_grant_q    <= 1'b0;
         bus_valid_q     <= 1'b0;
         bus_write_q     <= 1'b0;
         bus_address_q   <= 32'd0;
         bus_wdata_q     <= 32'd0;
         bus_strobe_q    <= 4'b0000;
         fetch_ready_q   <= 1'b0;
         fetch_data_q    <= 32'd0;
         mem_ready_q     <= 1'b0;
         mem_load_data_q <= 32'd0;
         off_q           <= 2'b00;
         size_q          <= 2'b00;
         signed_q        <= 1'b0;
      end else begin
         state_q         <= state_d;
         last_grant_q    <= last_grant_d;
         bus_valid_q     <= bus_valid_d;
         bus_write_q     <= bus_write_d;
         bus_address_q   <= bus_address_d;
         bus_wdata_q     <= bus_wdata_d;
         bus_strobe_q    <= bus_strobe_d;
         fetch_ready_q   <= fetch_ready_d;
         fetch_data_q    <= fetch_data_d;
         mem_ready_q     <= mem_ready_d;
         mem_load_data_q <= mem_load_data_d;
         off_q           <= off_d;
         size_q          <= size_d;
         signed_q        <= signed_d;
      end
   end

   assign bus_if.bus_valid     = bus_valid_q;
   assign bus_if.bus_write     = bus_write_q;
   assign bus_if.bus_address   = bus_address_q;
   assign bus_if.bus_wdata     = bus_wdata_q;
   assign bus_if.bus_strobe    = bus_strobe_q;
   assign bus_if.fetch_ready   = fetch_ready_q;
   assign bus_if.fetch_data    = fetch_data_q;
   assign bus_if.mem_ready     = mem_ready_q;
   assign bus_if.mem_load_data = mem_load_data_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter; inputs change and outputs are sampled on negedge.
// Covers the BUS_TIMEOUT_EN build as well when that macro is defined.
module tb_bus_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_pass   = 0;

   bus_arbiter_if bif ();

   bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_if (bif)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_mem(input logic ld, input logic st, input logic [31:0] addr,
                          input logic [31:0] data, input logic [1:0] size, input logic sgn);
      bif.mem_load       = ld;
      bif.mem_store      = st;
      bif.mem_address    = addr;
      bif.mem_store_data = data;
      bif.mem_size       = size;
      bif.mem_signed     = sgn;
   endtask

   task automatic store_case(input string tag, input logic [31:0] addr, input logic [31:0] data,
                             input logic [1:0] size, input logic [31:0] exp_addr,
                             input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
      set_mem(1'b0, 1'b1, addr, data, size, 1'b0);
      bif.bus_ready = 1'b0;
      tick();
      check({tag, "_addr"}, bif.bus_address, exp_addr);
      check({tag, "_strobe"}, 32'(bif.bus_strobe), 32'(exp_strb));
      check({tag, "_wdata"}, bif.bus_wdata, exp_wdata);
      check({tag, "_write"}, 32'(bif.bus_write), 32'd1);
      tick();
      check({tag, "_hold_valid"}, 32'(bif.bus_valid), 32'd1);
      check({tag, "_hold_wdata"}, bif.bus_wdata, exp_wdata);
      bif.bus_ready = 1'b1;
      tick();
      check({tag, "_ready"}, 32'(bif.mem_ready), 32'd1);
      check({tag, "_valid_off"}, 32'(bif.bus_valid), 32'd0);
      set_mem(1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
      bif.bus_ready = 1'b0;
      tick();
   endtask

   task automatic load_case(input string tag, input logic [31:0] addr, input logic [1:0] size,
                            input logic sgn, input logic [31:0] rdata, input logic [31:0] exp);
      set_mem(1'b1, 1'b0, addr, 32'd0, size, sgn);
      bif.bus_ready = 1'b1;
      bif.bus_rdata = rdata;
      tick();
      check({tag, "_valid"}, 32'(bif.bus_valid), 32'd1);
      tick();
      check({tag, "_ready"}, 32'(bif.mem_ready), 32'd1);
      check({tag, "_data"}, bif.mem_load_data, exp);
      set_mem(1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
      bif.bus_ready = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n             = 1'b0;
      bif.fetch_req     = 1'b0;
      bif.fetch_address = 32'd0;
      set_mem(1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
      bif.bus_ready     = 1'b0;
      bif.bus_rdata     = 32'd0;
      repeat (2) @(negedge clk);
      check("rst_valid", 32'(bif.bus_valid), 32'd0);
      check("rst_strobe", 32'(bif.bus_strobe), 32'd0);
      check("rst_addr", bif.bus_address, 32'd0);
      check("rst_fetch_ready", 32'(bif.fetch_ready), 32'd0);
      check("rst_mem_ready", 32'(bif.mem_ready), 32'd0);
      check("rst_fetch_data", bif.fetch_data, 32'd0);
      rst_n = 1'b1;
      tick();

      // Minimum-latency fetch
      bif.fetch_req     = 1'b1;
      bif.fetch_address = 32'h0000_0100;
      bif.bus_ready     = 1'b1;
      bif.bus_rdata     = 32'h0000_0013;
      tick();
      check("f_valid", 32'(bif.bus_valid), 32'd1);
      check("f_addr", bif.bus_address, 32'h0000_0100);
      check("f_write", 32'(bif.bus_write), 32'd0);
      check("f_early_ready", 32'(bif.fetch_ready), 32'd0);
      tick();
      check("f_ready", 32'(bif.fetch_ready), 32'd1);
      check("f_data", bif.fetch_data, 32'h0000_0013);
      check("f_valid_off", 32'(bif.bus_valid), 32'd0);
      check("f_error", 32'(bif.fetch_error), 32'd0);
      bif.fetch_req = 1'b0;
      bif.bus_rdata = 32'hFFFF_FFFF;
      tick();
      check("f_ready_pulse", 32'(bif.fetch_ready), 32'd0);
      check("f_data_hold", bif.fetch_data, 32'h0000_0013);

      // Simultaneous requests alternate MEM, FETCH, MEM, FETCH
      bif.fetch_req     = 1'b1;
      bif.fetch_address = 32'h0000_0200;
      set_mem(1'b1, 1'b0, 32'h0000_3000, 32'd0, 2'b10, 1'b0);
      bif.bus_ready     = 1'b1;
      bif.bus_rdata     = 32'hCAFE_F00D;
      for (int r = 0; r < 2; r++) begin
         tick();
         check("arb_mem_first", bif.bus_address, 32'h0000_3000);
         tick();
         check("arb_mem_ready", 32'(bif.mem_ready), 32'd1);
         check("arb_mem_data", bif.mem_load_data, 32'hCAFE_F00D);
         check("arb_no_fetch_ready", 32'(bif.fetch_ready), 32'd0);
         bif.mem_load = 1'b0;
         tick();
         check("arb_gap", 32'(bif.bus_valid), 32'd0);
         tick();
         check("arb_fetch_second", bif.bus_address, 32'h0000_0200);
         check("arb_fetch_valid", 32'(bif.bus_valid), 32'd1);
         tick();
         check("arb_fetch_ready", 32'(bif.fetch_ready), 32'd1);
         bif.mem_load = 1'b1;
         tick();
         check("arb_gap2", 32'(bif.bus_valid), 32'd0);
      end
      bif.fetch_req = 1'b0;
      set_mem(1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
      bif.bus_ready = 1'b0;
      tick();
      tick();

      store_case("st_b3", 32'h0000_1003, 32'h0000_00AB, 2'b00, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB);
      store_case("st_b1", 32'h0000_5001, 32'h0000_005A, 2'b00, 32'h0000_5000, 4'b0010, 32'h5A5A_5A5A);
      store_case("st_h2", 32'h0000_3002, 32'h0000_1234, 2'b01, 32'h0000_3000, 4'b1100, 32'h1234_1234);
      store_case("st_w",  32'h0000_4000, 32'hDEAD_BEEF, 2'b10, 32'h0000_4000, 4'b1111, 32'hDEAD_BEEF);

      load_case("ld_hs", 32'h0000_2002, 2'b01, 1'b1, 32'h8001_1234, 32'hFFFF_8001);
      load_case("ld_hu", 32'h0000_2002, 2'b01, 1'b0, 32'h8001_1234, 32'h0000_8001);
      load_case("ld_h0", 32'h0000_2000, 2'b01, 1'b1, 32'h8001_1234, 32'h0000_1234);
      load_case("ld_b3", 32'h0000_2003, 2'b00, 1'b1, 32'h8001_1234, 32'hFFFF_FF80);
      load_case("ld_b1", 32'h0000_2001, 2'b00, 1'b1, 32'h8001_1234, 32'h0000_0012);
      load_case("ld_b3u", 32'h0000_2003, 2'b00, 1'b0, 32'h8001_1234, 32'h0000_0080);

      // Reset in the middle of a stalled transfer
      set_mem(1'b1, 1'b0, 32'h0000_6000, 32'd0, 2'b10, 1'b0);
      bif.bus_ready = 1'b0;
      tick();
      check("mrst_valid_before", 32'(bif.bus_valid), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("mrst_valid_now", 32'(bif.bus_valid), 32'd0);
      check("mrst_strobe", 32'(bif.bus_strobe), 32'd0);
      check("mrst_load_data", bif.mem_load_data, 32'd0);
      set_mem(1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      bif.bus_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("mrst_no_valid", 32'(bif.bus_valid), 32'd0);
         check("mrst_no_ready", 32'(bif.mem_ready), 32'd0);
      end

      // Slave stuck not-ready
      set_mem(1'b1, 1'b0, 32'h0000_7000, 32'd0, 2'b10, 1'b0);
      bif.bus_ready = 1'b0;
      bif.bus_rdata = 32'h1122_3344;
      tick();
      check("stk_valid", 32'(bif.bus_valid), 32'd1);
`ifdef BUS_TIMEOUT_EN
      for (int i = 0; i < 3; i++) begin
         tick();
         check("tmo_wait_valid", 32'(bif.bus_valid), 32'd1);
         check("tmo_wait_ready", 32'(bif.mem_ready), 32'd0);
      end
      tick();
      check("tmo_valid_off", 32'(bif.bus_valid), 32'd0);
      check("tmo_ready", 32'(bif.mem_ready), 32'd1);
      check("tmo_error", 32'(bif.mem_error), 32'd1);
      check("tmo_data", bif.mem_load_data, 32'd0);
      set_mem(1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
      tick();
      check("tmo_error_pulse", 32'(bif.mem_error), 32'd0);
`else
      for (int i = 0; i < 6; i++) begin
         tick();
         check("stk_wait_valid", 32'(bif.bus_valid), 32'd1);
         check("stk_no_error", 32'(bif.mem_error), 32'd0);
      end
      bif.bus_ready = 1'b1;
      tick();
      check("stk_ready", 32'(bif.mem_ready), 32'd1);
      check("stk_error", 32'(bif.mem_error), 32'd0);
      check("stk_data", bif.mem_load_data, 32'h1122_3344);
      set_mem(1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
      bif.bus_ready = 1'b0;
      tick();
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
